cpu_mw: RTL and testbench

Parametrised multi-cycle accumulator-less CPU core, the successor of the fixed 8-bit `cpu`. It keeps the same five-state instruction sequencer and the same opcode map. Data width, address width and register count are configurable. Memory is reached through a request/acknowledge port, so the core tolerates wait-state RAM instead of assuming single-cycle synchronous RAM. It sits between the top-level run/halt controls and an external memory or RAM wrapper.

---
 rtl/cpu_mw.sv | 175 +++++++++++++++++
 tb/tb_cpu_mw.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mw.sv
// cpu_mw: multi-cycle CPU core with a request/acknowledge memory port; CPU_MW_TRAP_EN enables the undefined-opcode trap.
// Latency: 4 cycles per instruction with zero-wait memory, plus 1 cycle per cycle mem_ack is held low.
// Backpressure: every memory phase holds its request until mem_ack; mem_ack with no request pending is ignored.
module cpu_mw #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          halt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          waits,
    output logic          fetcha,
    output logic          fetchb,
    output logic          execa,
    output logic          execb,
    output logic [AW-1:0] pc,
    output logic          cflag,
    output logic          zflag,
    output logic          trap
);
    localparam int RW  = $clog2(NREG);
    localparam int DW1 = DW + 1;

    typedef enum logic [2:0] {S_WAIT, S_FETCHA, S_FETCHB, S_EXECA, S_EXECB} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] ira, irb;
    logic [DW-1:0] regs [NREG];

    logic [2:0]    cls, rf;
    logic [1:0]    sub;
    logic [RW-1:0] rsel, asel, bsel;
    assign cls  = ira[7:5];
    assign sub  = ira[4:3];
    assign rf   = ira[2:0];
    assign rsel = rf[RW-1:0];
    assign asel = irb[RW-1:0];
    assign bsel = irb[RW+2:3];

    logic is_hlt, is_ld, is_st, is_jmp, is_alu, is_undef, jmp_take;
    assign is_hlt   = (ira[7:0] == 8'h00);
    assign is_ld    = (cls == 3'b000) && (sub == 2'b01);
    assign is_st    = (cls == 3'b000) && (sub == 2'b10);
    assign is_jmp   = (cls == 3'b001) && (sub == 2'b00) && (!rf[2] || rf == 3'b111);
    assign is_alu   = (cls == 3'b100);
    assign is_undef = !(is_hlt || is_ld || is_st || is_jmp || is_alu);

    always_comb begin
        case (rf[1:0])
            2'b00:   jmp_take = cflag;
            2'b01:   jmp_take = !cflag;
            2'b10:   jmp_take = zflag;
            default: jmp_take = !zflag;
        endcase
        if (rf[2]) jmp_take = 1'b1;
    end

    // One extra bit so bit DW carries the carry/borrow out.
    logic [DW:0] op_a, op_b, alu_res;
    assign op_a = {1'b0, regs[asel]};
    assign op_b = {1'b0, regs[bsel]};
    always_comb begin
        case (sub)
            2'b00:   alu_res = op_a + DW1'(1);
            2'b01:   alu_res = op_a - DW1'(1);
            2'b10:   alu_res = op_a + op_b;
            default: alu_res = op_a - op_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_WAIT;
        else      state <= state_nxt;
    end

    // Request outputs depend only on state and IR, so they stay stable until the ack edge.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_WAIT:   if (run && !halt) state_nxt = S_FETCHA;
            S_FETCHA: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                if (mem_ack) state_nxt = S_FETCHB;
            end
            S_FETCHB: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                if (mem_ack) state_nxt = S_EXECA;
            end
            S_EXECA: begin
                if (is_ld) begin
                    mem_rd   = 1'b1;
                    mem_addr = irb[AW-1:0];
                    if (mem_ack) state_nxt = S_EXECB;
                end else if (is_st) begin
                    mem_wr    = 1'b1;
                    mem_addr  = irb[AW-1:0];
                    mem_wdata = regs[rsel];
                    if (mem_ack) state_nxt = S_EXECB;
                end else begin
                    state_nxt = S_EXECB;
                end
            end
            S_EXECB:  state_nxt = (is_hlt || halt || trap) ? S_WAIT : S_FETCHA;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            ira   <= '0;
            irb   <= '0;
            cflag <= 1'b0;
            zflag <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCHA: if (mem_ack) begin
                    ira <= mem_rdata;
                    pc  <= pc + AW'(1);
                end
                S_FETCHB: if (mem_ack) begin
                    irb <= mem_rdata;
                    pc  <= pc + AW'(1);
                end
                S_EXECA: begin
                    if (is_ld && mem_ack) regs[rsel] <= mem_rdata;
                    if (is_jmp && jmp_take) pc <= irb[AW-1:0];
                    if (is_alu) begin
                        regs[rsel] <= alu_res[DW-1:0];
                        cflag      <= alu_res[DW];
                        zflag      <= (alu_res[DW-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_MW_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    trap_q <= 1'b0;
        else if (state == S_WAIT && run && !halt)    trap_q <= 1'b0;
        else if (state == S_EXECA && is_undef)       trap_q <= 1'b1;
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Upper IR bits are carried but never decoded.
    logic unused_bits;
    assign unused_bits = ^{ira, irb, is_undef};

    assign waits  = (state == S_WAIT);
    assign fetcha = (state == S_FETCHA);
    assign fetchb = (state == S_FETCHB);
    assign execa  = (state == S_EXECA);
    assign execb  = (state == S_EXECB);
endmodule

// File: tb/tb_cpu_mw.sv
// Bench for cpu_mw: an 8-bit core on wait-state memory and a 16-bit/4-register core on zero-wait memory,
// checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_cpu_mw;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, halt, run8, run16;
    logic [7:0]  addr8, wdata8, pc8;
    logic [7:0]  rdata8;
    logic        rd8, wr8, wt8, fa8, fb8, ea8, eb8, c8, z8, trap8;
    logic        ack8;
    logic [7:0]  addr16, pc16;
    logic [15:0] wdata16, rdata16;
    logic        rd16, wr16, ack16, wt16, fa16, fb16, ea16, eb16, c16, z16, trap16;

    cpu_mw dut8 (
        .clk(clk), .rst(rst), .run(run8), .halt(halt),
        .mem_addr(addr8), .mem_rd(rd8), .mem_wr(wr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .mem_ack(ack8),
        .waits(wt8), .fetcha(fa8), .fetchb(fb8), .execa(ea8), .execb(eb8),
        .pc(pc8), .cflag(c8), .zflag(z8), .trap(trap8)
    );

    cpu_mw #(.DW(16), .AW(8), .NREG(4)) dut16 (
        .clk(clk), .rst(rst), .run(run16), .halt(halt),
        .mem_addr(addr16), .mem_rd(rd16), .mem_wr(wr16), .mem_wdata(wdata16),
        .mem_rdata(rdata16), .mem_ack(ack16),
        .waits(wt16), .fetcha(fa16), .fetchb(fb16), .execa(ea16), .execb(eb16),
        .pc(pc16), .cflag(c16), .zflag(z16), .trap(trap16)
    );

    logic [7:0]  mem8  [256];
    logic [15:0] mem16 [256];
    int  ack_dly, rnd_dly, wcnt;
    bit  rand_ack;
    int  vectors, miscompares;

    // Wait-state memory for the 8-bit core: ack after ack_dly idle cycles of a held request.
    initial begin ack8 = 1'b0; rdata8 = '0; wcnt = 0; rnd_dly = 0; end
    always @(negedge clk) begin
        if (ack8) begin
            wcnt = 0;
            rnd_dly = $urandom_range(0, 2);
        end
        if (rd8 || wr8) begin
            if (wcnt >= (rand_ack ? rnd_dly : ack_dly)) begin
                ack8   = 1'b1;
                rdata8 = mem8[addr8];
                if (wr8) mem8[addr8] = wdata8;
            end else begin
                ack8 = 1'b0;
                wcnt++;
            end
        end else begin
            ack8 = 1'b0;
            wcnt = 0;
        end
    end

    assign ack16   = rd16 | wr16;
    assign rdata16 = mem16[addr16];
    always @(posedge clk) if (wr16) mem16[addr16] <= wdata16;

    task automatic clear_mems;
        for (int i = 0; i < 256; i++) begin mem8[i] = 8'h00; mem16[i] = 16'h0000; end
    endtask

    task automatic apply_reset;
        rst = 1'b0; run8 = 1'b0; run16 = 1'b0; halt = 1'b0; ack_dly = 0; rand_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start(input bit sel16);
        @(negedge clk);
        if (sel16) run16 = 1'b1; else run8 = 1'b1;
        @(posedge clk); #1;
        run8 = 1'b0; run16 = 1'b0;
    endtask

    task automatic wait_idle(input bit sel16, input int budget, output int cyc);
        cyc = 0;
        while (((sel16 ? wt16 : wt8) == 1'b0) && cyc < budget) begin
            @(posedge clk); #1; cyc++;
        end
        vectors++;
        if ((sel16 ? wt16 : wt8) !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_idle: waits=%b after %0d cycles, required 1", sel16 ? wt16 : wt8, cyc);
        end
    endtask

    task automatic test_reset;
        clear_mems();
        rst = 1'b0; run8 = 1'b0; run16 = 1'b0; halt = 1'b0; ack_dly = 0; rand_ack = 1'b0;
        #3;
        vectors++; if ({wt8, fa8, fb8, ea8, eb8} !== 5'b10000) begin miscompares++; $display("FAIL reset_state got %b want 10000", {wt8, fa8, fb8, ea8, eb8}); end
        vectors++; if (pc8 !== 8'h00) begin miscompares++; $display("FAIL reset_pc got %h want 00", pc8); end
        vectors++; if ({c8, z8, trap8} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {c8, z8, trap8}); end
        vectors++; if ({rd8, wr8, addr8, wdata8} !== 18'h0) begin miscompares++; $display("FAIL reset_mem got %h want 0", {rd8, wr8, addr8, wdata8}); end
        vectors++; if ({wt16, pc16, wdata16} !== {1'b1, 24'h0}) begin miscompares++; $display("FAIL reset_dut16 got %h want 1000000", {wt16, pc16, wdata16}); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (dut8.regs[i] !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d got %h want 00", i, dut8.regs[i]); end
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset_mid_fetch;
        apply_reset(); clear_mems();
        mem8[0] = 8'h81; mem8[1] = 8'h00;
        start(0);
        repeat (2) begin @(posedge clk); #1; end
        ack_dly = 5;
        repeat (2) begin @(posedge clk); #1; end
        vectors++; if ({fa8, rd8, pc8, addr8} !== {2'b11, 8'h02, 8'h02}) begin miscompares++; $display("FAIL midfetch_pre got %h want 30202", {fa8, rd8, pc8, addr8}); end
        #2 rst = 1'b0;
        #1;
        vectors++; if ({rd8, wt8, pc8} !== {2'b01, 8'h00}) begin miscompares++; $display("FAIL midfetch_reset rd/waits/pc got %h want 100", {rd8, wt8, pc8}); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_ld_inc_jc;
        int cyc;
        apply_reset(); clear_mems();
        mem8[0] = 8'h09; mem8[1] = 8'h10; mem8[2] = 8'h82; mem8[3] = 8'h01;
        mem8[4] = 8'h20; mem8[5] = 8'h00; mem8[8'h10] = 8'hFF;
        start(0);
        repeat (12) begin @(posedge clk); #1; end
        vectors++; if ({fa8, pc8} !== 9'h100) begin miscompares++; $display("FAIL ldincjc_fetcha_pc got %h want 100", {fa8, pc8}); end
        vectors++; if (dut8.regs[1] !== 8'hFF) begin miscompares++; $display("FAIL ldincjc_r1 got %h want ff", dut8.regs[1]); end
        vectors++; if (dut8.regs[2] !== 8'h00) begin miscompares++; $display("FAIL ldincjc_r2 got %h want 00", dut8.regs[2]); end
        vectors++; if ({c8, z8} !== 2'b11) begin miscompares++; $display("FAIL ldincjc_flags got %b want 11", {c8, z8}); end
        halt = 1'b1;
        wait_idle(0, 50, cyc);
        halt = 1'b0;
    endtask

    task automatic test_st_wait;
        int cyc, wrn, both, badv;
        apply_reset(); clear_mems();
        mem8[0] = 8'h0B; mem8[1] = 8'h30; mem8[2] = 8'h13; mem8[3] = 8'h20;
        mem8[8'h30] = 8'hA5;
        ack_dly = 3;
        start(0);
        cyc = 0; wrn = 0; both = 0; badv = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wt8) break;
            cyc++;
            if (rd8 && wr8) both++;
            if (wr8) begin
                wrn++;
                if (addr8 !== 8'h20 || wdata8 !== 8'hA5) badv++;
            end
        end
        vectors++; if (wt8 !== 1'b1) begin miscompares++; $display("FAIL st_reach_wait got %b want 1", wt8); end
        vectors++; if (wrn != 4) begin miscompares++; $display("FAIL st_wr_cycles got %0d want 4", wrn); end
        vectors++; if (both != 0) begin miscompares++; $display("FAIL st_rd_and_wr got %0d cycles want 0", both); end
        vectors++; if (badv != 0) begin miscompares++; $display("FAIL st_addr_wdata got %0d bad cycles want 0", badv); end
        vectors++; if (cyc != 36) begin miscompares++; $display("FAIL st_total_cycles got %0d want 36", cyc); end
        vectors++; if (mem8[8'h20] !== 8'hA5) begin miscompares++; $display("FAIL st_mem got %h want a5", mem8[8'h20]); end
    endtask

    task automatic test_halt;
        int cyc, left;
        bit found;
        apply_reset(); clear_mems();
        mem8[0] = 8'h27; mem8[1] = 8'h05; mem8[5] = 8'h80; mem8[6] = 8'h00;
        mem8[7] = 8'h27; mem8[8] = 8'h05;
        start(0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (fb8 && pc8 == 8'h06) found = 1'b1;
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL halt_fetchb_pc6 seen=%b want 1", found); end
        halt = 1'b1;
        wait_idle(0, 20, cyc);
        vectors++; if (pc8 !== 8'h07) begin miscompares++; $display("FAIL halt_pc got %h want 07", pc8); end
        vectors++; if (dut8.regs[0] !== 8'h01) begin miscompares++; $display("FAIL halt_r0 got %h want 01", dut8.regs[0]); end
        run8 = 1'b1; left = 0;
        repeat (5) begin @(negedge clk); if (!wt8) left++; end
        vectors++; if (left != 0) begin miscompares++; $display("FAIL halt_blocks_run left WAIT %0d cycles want 0", left); end
        run8 = 1'b0; halt = 1'b0;
    endtask

    task automatic test_sub16;
        int cyc;
        apply_reset(); clear_mems();
        mem16[0] = 16'h0081; mem16[1] = 16'h0000; mem16[2] = 16'h009A; mem16[3] = 16'h0008;
        mem16[4] = 16'h0023; mem16[5] = 16'h0040;
        start(1);
        wait_idle(1, 100, cyc);
        vectors++; if (dut16.regs[2] !== 16'hFFFF) begin miscompares++; $display("FAIL sub16_r2 got %h want ffff", dut16.regs[2]); end
        vectors++; if ({c16, z16} !== 2'b10) begin miscompares++; $display("FAIL sub16_flags got %b want 10", {c16, z16}); end
        vectors++; if (pc16 !== 8'h42) begin miscompares++; $display("FAIL sub16_jnz_pc got %h want 42", pc16); end
        vectors++; if (cyc != 16) begin miscompares++; $display("FAIL sub16_cycles got %0d want 16", cyc); end
    endtask

    task automatic test_undef;
        int cyc;
        apply_reset(); clear_mems();
        mem8[0] = 8'h81; mem8[1] = 8'h00; mem8[2] = 8'hE0; mem8[3] = 8'h00;
        mem8[4] = 8'h81; mem8[5] = 8'h01;
        start(0);
        wait_idle(0, 100, cyc);
`ifdef CPU_MW_TRAP_EN
        vectors++; if ({trap8, pc8} !== 9'h104) begin miscompares++; $display("FAIL undef_trap_pc got %h want 104", {trap8, pc8}); end
        vectors++; if (dut8.regs[1] !== 8'h01) begin miscompares++; $display("FAIL undef_r1 got %h want 01", dut8.regs[1]); end
        vectors++; if (cyc != 8) begin miscompares++; $display("FAIL undef_cycles got %0d want 8", cyc); end
        start(0);
        vectors++; if (trap8 !== 1'b0) begin miscompares++; $display("FAIL undef_trap_clear got %b want 0", trap8); end
        wait_idle(0, 100, cyc);
`else
        vectors++; if ({trap8, pc8} !== 9'h008) begin miscompares++; $display("FAIL undef_trap_pc got %h want 008", {trap8, pc8}); end
        vectors++; if (dut8.regs[1] !== 8'h02) begin miscompares++; $display("FAIL undef_r1 got %h want 02", dut8.regs[1]); end
        vectors++; if (cyc != 16) begin miscompares++; $display("FAIL undef_cycles got %0d want 16", cyc); end
`endif
    endtask

    task automatic test_random;
        int p, n, kind, r, cc, cyc, a, b, x, y, res, mpc;
        int mm [256];
        int mr [8];
        bit mc, mz, take;
        logic [7:0] ira, irb;
        for (int prog = 0; prog < 20; prog++) begin
            apply_reset(); clear_mems(); rand_ack = 1'b1;
            for (int i = 128; i < 256; i++) mem8[i] = 8'($urandom);
            p = 0; n = $urandom_range(6, 16);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 9);
                r = $urandom_range(0, 7);
                if (kind < 2) begin
                    ira = 8'h08 | 8'(r); irb = 8'h80 | 8'($urandom_range(0, 127));
                end else if (kind == 2) begin
                    ira = 8'h10 | 8'(r); irb = 8'h80 | 8'($urandom_range(0, 127));
                end else if (kind < 5) begin
                    cc = $urandom_range(0, 4); if (cc == 4) cc = 7;
                    ira = 8'h20 | 8'(cc);
                    irb = 8'(p + 2 + ((i < n - 1) ? 2 * $urandom_range(0, 1) : 0));
                end else begin
                    ira = 8'h80 | 8'($urandom_range(0, 31)); irb = 8'($urandom);
                end
                mem8[p] = ira; mem8[p + 1] = irb; p += 2;
            end
            for (int i = 0; i < 256; i++) mm[i] = mem8[i];
            for (int i = 0; i < 8; i++) mr[i] = 0;
            mc = 0; mz = 0; mpc = 0;
            for (int step = 0; step < 64; step++) begin
                a = mm[mpc]; b = mm[(mpc + 1) & 255]; mpc = (mpc + 2) & 255;
                if (a == 0) break;
                r = a & 7;
                if ((a >> 3) == 1) mr[r] = mm[b];
                else if ((a >> 3) == 2) mm[b] = mr[r];
                else if ((a >> 5) == 1) begin
                    take = (r == 0) ? mc : (r == 1) ? !mc : (r == 2) ? mz : (r == 3) ? !mz : 1'b1;
                    if (take) mpc = b;
                end else begin
                    x = mr[b & 7]; y = mr[(b >> 3) & 7];
                    case ((a >> 3) & 3)
                        0: res = x + 1;
                        1: res = x - 1;
                        2: res = x + y;
                        default: res = x - y;
                    endcase
                    mc = (res < 0) || (res > 255);
                    mr[r] = res & 255;
                    mz = (mr[r] == 0);
                end
            end
            start(0);
            wait_idle(0, 2000, cyc);
            for (int i = 0; i < 8; i++) begin
                vectors++; if (dut8.regs[i] !== 8'(mr[i])) begin miscompares++; $display("FAIL rand%0d_r%0d got %h want %h", prog, i, dut8.regs[i], 8'(mr[i])); end
            end
            vectors++; if ({c8, z8} !== {mc, mz}) begin miscompares++; $display("FAIL rand%0d_flags got %b want %b", prog, {c8, z8}, {mc, mz}); end
            vectors++; if (pc8 !== 8'(mpc)) begin miscompares++; $display("FAIL rand%0d_pc got %h want %h", prog, pc8, 8'(mpc)); end
            for (int i = 128; i < 256; i++) begin
                vectors++; if (mem8[i] !== 8'(mm[i])) begin miscompares++; $display("FAIL rand%0d_mem%h got %h want %h", prog, i[7:0], mem8[i], 8'(mm[i])); end
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        test_reset();
        test_reset_mid_fetch();
        test_ld_inc_jc();
        test_st_wait();
        test_halt();
        test_sub16();
        test_undef();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
